map_scroll_renderer: RTL and testbench
======================================

// Module: map_scroll_renderer
// PURPOSE
//  Parametrised full-screen background renderer. Scales an IMG_W x IMG_H indexed bitmap onto
//  the SCREEN_W x SCREEN_H VGA raster, adds per-frame scroll with wrap or clip, and applies
//  transparency. Uses divider-free incremental scaling and a pipeline of ROM_LAT+2 cycles.
//  Drives an external sync index ROM and an external combinational palette. Sits between
//  vga_controller (DrawX/DrawY/blank) and the colour mux.
// PARAMETERS
//  SCREEN_W  640   visible raster width (pixels)
//  SCREEN_H  480   visible raster height (lines)
//  IMG_W     468   bitmap width; must satisfy 1 <= IMG_W <= SCREEN_W
//  IMG_H     468   bitmap height; must satisfy 1 <= IMG_H <= SCREEN_H
//  ADDR_W    18    ROM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
//  IDX_W     4     palette index width
//  ROM_LAT   1     ROM read latency in vga_clk cycles (>=1)
//  WRAP      1     1: scroll wraps modulo image; 0: out-of-image pixels show bg colour
//  TRANSP    0     palette index rendered as bg colour (TRANSP >= 2**IDX_W disables)
// PORTS
//  vga_clk      in   1       pixel clock; all state on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  DrawX        in   10      current pixel column
//  DrawY        in   10      current pixel row
//  blank        in   1       1 = visible pixel, 0 = blanking
//  scroll_x     in   10      requested horizontal offset (source pixels)
//  scroll_y     in   10      requested vertical offset (source pixels)
//  bg_rgb       in   12      {r,g,b} colour for clipped/transparent pixels
//  rom_addr     out  ADDR_W  index ROM address (registered)
//  rom_q        in   IDX_W   ROM data, valid ROM_LAT cycles after rom_addr
//  pal_index    out  IDX_W   = rom_q (combinational pass-through to palette)
//  pal_rgb      in   12      palette colour for pal_index (combinational)
//  red,green,blue out 4 each pixel colour (registered)
// BEHAVIOUR
//  - Reset: rom_addr, red, green, blue, all counters, latched scroll = 0; pipeline valids = 0.
//  - Frame start: cycle with DrawX==0 && DrawY==0 latches scroll_x/scroll_y into sx_off/sy_off;
//    values >= IMG_W/IMG_H are clamped to IMG_W-1/IMG_H-1. Mid-frame scroll changes ignored.
//  - Column DDA: DrawX==0 -> sx=0, fx=0. DrawX changed (!=prev) -> fx+=IMG_W; if fx>=SCREEN_W
//    then fx-=SCREEN_W, sx++. Result sx == floor(DrawX*IMG_W/SCREEN_W) for unit-step DrawX.
//  - Row DDA identical on DrawY with IMG_H/SCREEN_H (sy, fy); DrawY==0 resets. A row step and a
//    column reset in the same cycle are both applied.
//  - Effective coords: ex=sx+sx_off, ey=sy+sy_off. WRAP=1: subtract IMG_W/IMG_H once if >=.
//    WRAP=0: ex>=IMG_W or ey>=IMG_H marks pixel clipped.
//  - rom_addr <= ey*IMG_W + ex (constant multiply), registered 1 cycle after DrawX/DrawY
//    sample; clipped pixels keep rom_addr=0.
//  - blank and clipped flags delayed by shift register to match ROM_LAT.
//  - Output stage (input cycle t -> colour at t+2+ROM_LAT): if !blank_d -> 0,0,0; else if
//    clipped_d or rom_q==TRANSP -> bg_rgb; else pal_rgb.
//  - Reset mid-frame: outputs black until pipeline refills; scroll 0 until next frame start.
//  - Non-unit DrawX jumps are not re-synchronised until DrawX==0 (documented limitation).
// TESTING
//  1. Defaults, scroll 0, sweep DrawX 0..639 on DrawY=0 -> rom_addr at DrawX=320 is 234,
//     at 639 is 467; sx never skips >1.
//  2. DrawX=639, DrawY=479 -> rom_addr = 467*468+467 = 219023.
//  3. WRAP=1, scroll_x=10 latched at frame start, DrawX=639 row 0 -> rom_addr=9;
//     scroll_x changed to 50 mid-frame -> unchanged until next frame.
//  4. WRAP=0, scroll_x=10, DrawX=639 -> output = bg_rgb 12'h0F0; DrawX=0 -> rom_addr=10.
//  5. ROM_LAT=1, model ROM returns TRANSP=0 at addr 5, 3 elsewhere -> colour at t+3; idx 0 ->
//     bg_rgb, idx 3 -> pal_rgb; blank=0 -> 0,0,0.
//  6. Assert reset_n low mid-line (DrawX=200) -> red/green/blue/rom_addr=0 immediately;
//     release -> correct pixels from next DrawX==0, scroll=0 until frame start.

Source files
------------

// File: rtl/map_scroll_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : map_scroll_renderer
//  Description : Full-screen background renderer. Scales an IMG_W x IMG_H
//                indexed bitmap onto the SCREEN_W x SCREEN_H raster using
//                divider-free incremental (DDA) scaling. It adds a per-frame
//                scroll offset that either wraps or clips, and applies a
//                transparent palette index. The pipeline is ROM_LAT+2 cycles
//                from DrawX/DrawY to the RGB output.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    vga_clk            pixel clock, all state on rising edge
//    reset_n            asynchronous active-low reset
//    DrawX / DrawY      current raster column / row
//    blank              1 = visible pixel, 0 = blanking interval
//    scroll_x/scroll_y  requested offset in source pixels, sampled at frame start
//    bg_rgb             colour for clipped or transparent pixels
//    rom_addr           registered index-ROM address
//    rom_q              index-ROM data, valid ROM_LAT cycles after rom_addr
//    pal_index          rom_q forwarded to the external palette
//    pal_rgb            palette colour for pal_index (combinational)
//    red/green/blue     registered pixel colour
// ============================================================================
module map_scroll_renderer #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int IMG_W    = 468,
    parameter int IMG_H    = 468,
    parameter int ADDR_W   = 18,
    parameter int IDX_W    = 4,
    parameter int ROM_LAT  = 1,
    parameter int WRAP     = 1,
    parameter int TRANSP   = 0
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        scroll_x,
    input  logic [9:0]        scroll_y,
    input  logic [11:0]       bg_rgb,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    // Widths sized so that source coord + offset (< 2*IMG) and the DDA
    // fraction + step (< 2*SCREEN) never overflow.
    localparam int XW  = $clog2(2 * IMG_W);
    localparam int YW  = $clog2(2 * IMG_H);
    localparam int FXW = $clog2(2 * SCREEN_W);
    localparam int FYW = $clog2(2 * SCREEN_H);

    localparam logic [FXW-1:0]    C_IMG_W_F    = FXW'(IMG_W);
    localparam logic [FXW-1:0]    C_SCR_W_F    = FXW'(SCREEN_W);
    localparam logic [FYW-1:0]    C_IMG_H_F    = FYW'(IMG_H);
    localparam logic [FYW-1:0]    C_SCR_H_F    = FYW'(SCREEN_H);
    localparam logic [XW-1:0]     C_IMG_W_X    = XW'(IMG_W);
    localparam logic [XW-1:0]     C_IMG_W_M1_X = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     C_IMG_H_Y    = YW'(IMG_H);
    localparam logic [YW-1:0]     C_IMG_H_M1_Y = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] C_IMG_W_A    = ADDR_W'(IMG_W);
    localparam logic [IDX_W-1:0]  C_TRANSP     = IDX_W'(TRANSP);
    localparam bit                TRANSP_EN    = (TRANSP < (1 << IDX_W));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [9:0]        prev_x_q,    prev_x_d;
    logic [9:0]        prev_y_q,    prev_y_d;
    logic [FXW-1:0]    fx_q,        fx_d;
    logic [XW-1:0]     sx_q,        sx_d;
    logic [FYW-1:0]    fy_q,        fy_d;
    logic [YW-1:0]     sy_q,        sy_d;
    logic [XW-1:0]     sx_off_q,    sx_off_d;
    logic [YW-1:0]     sy_off_q,    sy_off_d;
    logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
    logic [ROM_LAT:0]  blank_pipe_q, blank_pipe_d;
    logic [ROM_LAT:0]  clip_pipe_q,  clip_pipe_d;
    logic [11:0]       rgb_q,       rgb_d;

    // Combinational intermediates
    logic              frame_start;
    logic [FXW-1:0]    fx_sum;
    logic [FYW-1:0]    fy_sum;
    logic [XW-1:0]     ex_sum, ex;
    logic [YW-1:0]     ey_sum, ey;
    logic              clipped;

    // ------------------------------------------------------------------
    // Scroll latch, scaling DDA and address generation
    // ------------------------------------------------------------------
    always_comb begin
        frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

        // Offsets are only taken at frame start so a scroll change never
        // tears a frame; out-of-range requests clamp to the last pixel.
        sx_off_d = sx_off_q;
        sy_off_d = sy_off_q;
        if (frame_start) begin
            sx_off_d = (32'(scroll_x) >= IMG_W) ? C_IMG_W_M1_X : XW'(scroll_x);
            sy_off_d = (32'(scroll_y) >= IMG_H) ? C_IMG_H_M1_Y : YW'(scroll_y);
        end

        prev_x_d = DrawX;
        prev_y_d = DrawY;

        // Column DDA: one IMG_W step per raster column, carry into sx
        // every time the fraction passes SCREEN_W.
        fx_sum = fx_q + C_IMG_W_F;
        fx_d   = fx_q;
        sx_d   = sx_q;
        if (DrawX == 10'd0) begin
            fx_d = '0;
            sx_d = '0;
        end else if (DrawX != prev_x_q) begin
            if (fx_sum >= C_SCR_W_F) begin
                fx_d = fx_sum - C_SCR_W_F;
                sx_d = sx_q + XW'(1);
            end else begin
                fx_d = fx_sum;
            end
        end

        // Row DDA, independent of the column DDA so both may act together.
        fy_sum = fy_q + C_IMG_H_F;
        fy_d   = fy_q;
        sy_d   = sy_q;
        if (DrawY == 10'd0) begin
            fy_d = '0;
            sy_d = '0;
        end else if (DrawY != prev_y_q) begin
            if (fy_sum >= C_SCR_H_F) begin
                fy_d = fy_sum - C_SCR_H_F;
                sy_d = sy_q + YW'(1);
            end else begin
                fy_d = fy_sum;
            end
        end

        // Effective source coordinate. Both terms are < IMG so a single
        // conditional subtract is a full modulo.
        clipped = 1'b0;
        ex_sum  = sx_d + sx_off_d;
        ey_sum  = sy_d + sy_off_d;
        ex      = ex_sum;
        ey      = ey_sum;
        if (ex_sum >= C_IMG_W_X) begin
            if (WRAP != 0) ex = ex_sum - C_IMG_W_X;
            else           clipped = 1'b1;
        end
        if (ey_sum >= C_IMG_H_Y) begin
            if (WRAP != 0) ey = ey_sum - C_IMG_H_Y;
            else           clipped = 1'b1;
        end

        rom_addr_d = clipped ? '0 : (ADDR_W'(ey) * C_IMG_W_A + ADDR_W'(ex));

        // Delay blank/clip alongside the address so they meet rom_q.
        blank_pipe_d = {blank_pipe_q[ROM_LAT-1:0], blank};
        clip_pipe_d  = {clip_pipe_q[ROM_LAT-1:0], clipped};
    end

    // ------------------------------------------------------------------
    // Colour selection
    // ------------------------------------------------------------------
    always_comb begin
        rgb_d = 12'h000;
        if (blank_pipe_q[ROM_LAT]) begin
            if (clip_pipe_q[ROM_LAT] || (TRANSP_EN && (rom_q == C_TRANSP)))
                rgb_d = bg_rgb;
            else
                rgb_d = pal_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            fx_q         <= '0;
            sx_q         <= '0;
            fy_q         <= '0;
            sy_q         <= '0;
            sx_off_q     <= '0;
            sy_off_q     <= '0;
            rom_addr_q   <= '0;
            blank_pipe_q <= '0;
            clip_pipe_q  <= '0;
            rgb_q        <= '0;
        end else begin
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            fx_q         <= fx_d;
            sx_q         <= sx_d;
            fy_q         <= fy_d;
            sy_q         <= sy_d;
            sx_off_q     <= sx_off_d;
            sy_off_q     <= sy_off_d;
            rom_addr_q   <= rom_addr_d;
            blank_pipe_q <= blank_pipe_d;
            clip_pipe_q  <= clip_pipe_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pal_index = rom_q;
    assign red       = rgb_q[11:8];
    assign green     = rgb_q[7:4];
    assign blue      = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_map_scroll_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_map_scroll_renderer
//  Description : Directed bench for map_scroll_renderer with default geometry.
//                Instance A wraps, instance B clips; both share the inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_map_scroll_renderer;

    localparam int          IW   = 468;
    localparam int          IH   = 468;
    localparam int          SW   = 640;
    localparam int          SH   = 480;
    localparam logic [11:0] BG   = 12'h0F0;
    localparam logic [11:0] PAL3 = 12'hABC;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, scroll_x, scroll_y;
    logic        blank;
    logic [11:0] bg_rgb;

    logic [17:0] addr_a, addr_b;
    logic [3:0]  rq_a, rq_b, pidx_a, pidx_b;
    logic [11:0] prgb_a, prgb_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [11:0] rgb_a, rgb_b;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_col [0:639];

    always #5 vga_clk = ~vga_clk;

    // ROM model, latency 1: index 0 (transparent) at address 5, 3 elsewhere.
    always @(posedge vga_clk) begin
        rq_a <= (addr_a == 18'd5) ? 4'd0 : 4'd3;
        rq_b <= (addr_b == 18'd5) ? 4'd0 : 4'd3;
    end
    assign prgb_a = (pidx_a == 4'd3) ? PAL3 : 12'h555;
    assign prgb_b = (pidx_b == 4'd3) ? PAL3 : 12'h555;
    assign rgb_a  = {r_a, g_a, b_a};
    assign rgb_b  = {r_b, g_b, b_b};

    map_scroll_renderer #(.WRAP(1)) u_dut_a (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .scroll_x(scroll_x), .scroll_y(scroll_y), .bg_rgb(bg_rgb),
        .rom_addr(addr_a), .rom_q(rq_a), .pal_index(pidx_a), .pal_rgb(prgb_a),
        .red(r_a), .green(g_a), .blue(b_a)
    );

    map_scroll_renderer #(.WRAP(0)) u_dut_b (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .scroll_x(scroll_x), .scroll_y(scroll_y), .bg_rgb(bg_rgb),
        .rom_addr(addr_b), .rom_q(rq_b), .pal_index(pidx_b), .pal_rgb(prgb_b),
        .red(r_b), .green(g_b), .blue(b_b)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sxm(input int x);
        return (x * IW) / SW;
    endfunction

    function automatic int sym(input int y);
        return (y * IH) / SH;
    endfunction

    initial begin
        int e;
        reset_n  = 1'b0;
        DrawX    = 10'd0;
        DrawY    = 10'd0;
        blank    = 1'b1;
        scroll_x = 10'd0;
        scroll_y = 10'd0;
        bg_rgb   = BG;
        #1;
        check("reset_addr", 32'(addr_a), 32'd0);
        check("reset_rgb",  32'(rgb_a),  32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Row 0 sweep, scroll 0: scaling, plus transparency/blank colour
        // pipeline checked three cycles after each input.
        for (int x = 0; x < 640; x++) begin
            DrawX = 10'(x);
            blank = ((x % 7) != 3);
            if (!blank)                exp_col[x] = 12'h000;
            else if (sxm(x) == 5)      exp_col[x] = BG;
            else                       exp_col[x] = PAL3;
            tick();
            check("row0_addr", 32'(addr_a), 32'(sxm(x)));
            if (x == 320) check("addr_x320", 32'(addr_a), 32'd234);
            if (x >= 2) begin
                check("col_a", 32'(rgb_a), 32'(exp_col[x-2]));
                check("col_b", 32'(rgb_b), 32'(exp_col[x-2]));
            end
        end
        blank = 1'b1;

        // Row DDA: step rows at column 0, then sweep the last line.
        for (int y = 1; y < 480; y++) begin
            DrawY = 10'(y);
            DrawX = 10'd0;
            tick();
            check("rowdda_addr", 32'(addr_a), 32'(sym(y) * IW));
        end
        for (int x = 1; x < 640; x++) begin
            DrawX = 10'(x);
            tick();
            check("lastrow_addr", 32'(addr_a), 32'(sym(479) * IW + sxm(x)));
        end
        check("addr_corner", 32'(addr_a), 32'd219023);

        // Frame start with scroll_x=10; change request mid-frame.
        DrawX = 10'd0; DrawY = 10'd0; scroll_x = 10'd10;
        tick();
        check("scroll_x0_a", 32'(addr_a), 32'd10);
        check("scroll_x0_b", 32'(addr_b), 32'd10);
        for (int x = 1; x < 640; x++) begin
            DrawX = 10'(x);
            if (x == 300) scroll_x = 10'd50;
            tick();
            e = sxm(x) + 10;
            if (e >= IW) e = e - IW;
            check("scroll_wrap", 32'(addr_a), 32'(e));
        end
        check("wrap_x639", 32'(addr_a), 32'd9);
        check("clip_addr", 32'(addr_b), 32'd0);
        tick();
        tick();
        check("wrap_col", 32'(rgb_a), 32'(PAL3));
        check("clip_col", 32'(rgb_b), 32'(BG));

        // New frame picks up the pending scroll_x=50.
        DrawX = 10'd0; DrawY = 10'd0;
        tick();
        check("next_frame", 32'(addr_a), 32'd50);

        // Clamp of out-of-range scroll values.
        scroll_x = 10'd600; scroll_y = 10'd500;
        tick();
        check("clamp_a", 32'(addr_a), 32'd219023);
        check("clamp_b", 32'(addr_b), 32'd219023);

        // Vertical wrap vs clip at the bottom line, scroll_y=10.
        scroll_x = 10'd0; scroll_y = 10'd10;
        tick();
        check("sy10_row0", 32'(addr_a), 32'd4680);
        for (int y = 1; y < 480; y++) begin
            DrawY = 10'(y);
            tick();
        end
        check("wrap_y", 32'(addr_a), 32'd4212);
        check("clip_y", 32'(addr_b), 32'd0);

        // Mid-line reset.
        DrawX = 10'd0; DrawY = 10'd0; scroll_x = 10'd20; scroll_y = 10'd0;
        tick();
        check("sx20", 32'(addr_a), 32'd20);
        for (int x = 1; x <= 200; x++) begin
            DrawX = 10'(x);
            tick();
        end
        check("pre_reset_col", 32'(rgb_a), 32'(PAL3));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_rgb",  32'(rgb_a),  32'd0);
        tick();
        check("rst_hold_rgb", 32'(rgb_b), 32'd0);
        reset_n = 1'b1;
        for (int x = 201; x < 640; x++) begin
            DrawX = 10'(x);
            tick();
        end
        DrawY = 10'd1;
        for (int x = 0; x < 640; x++) begin
            DrawX = 10'(x);
            tick();
            check("post_rst_addr", 32'(addr_a), 32'(sxm(x)));
        end
        tick();
        tick();
        check("post_rst_col", 32'(rgb_a), 32'(PAL3));
        DrawX = 10'd0; DrawY = 10'd0;
        tick();
        check("post_rst_frame", 32'(addr_a), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
